// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-memory protocol and the memory arbiter.
package cpu_types_pkg;

    localparam int CPU_ID_W = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    typedef enum logic {
        KIND_I = 1'b0,
        KIND_D = 1'b1
    } arb_kind_t;

    typedef struct packed {
        arb_kind_t             kind;
        logic [CPU_ID_W-1:0]   cpu;
    } arb_owner_t;

    // Successor of a CPU index, wrapping at n.
    function automatic logic [CPU_ID_W-1:0] next_cpu(input logic [CPU_ID_W-1:0] cpu,
                                                     input int unsigned n);
        logic [CPU_ID_W-1:0] nxt;
        if (32'(cpu) + 32'd1 >= n) begin
            nxt = '0;
        end else begin
            nxt = cpu + CPU_ID_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above rr, wrapping.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan candidates starting at rr; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand_s;
        logic             hit_s;
        valid  = 1'b0;
        idx    = '0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand_s = IDX_W'((int'(rr) + i) % N);
            hit_s  = !valid && req[cand_s];
            idx    = hit_s ? cand_s : idx;
            valid  = valid | hit_s;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates per-CPU icache/dcache word requests onto one RAM port.
// Define MEM_ARBITER_BLOCK_LOCK_EN to keep dcache two-word blocks atomic.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  word_t [CPUS-1:0]     iaddr,
    output logic [CPUS-1:0]      iwait,
    output word_t [CPUS-1:0]     iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  word_t [CPUS-1:0]     daddr,
    input  word_t [CPUS-1:0]     dstore,
    output logic [CPUS-1:0]      dwait,
    output word_t [CPUS-1:0]     dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate
);

    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t        state_r;
    arb_owner_t        owner_r;
    logic [IDX_W-1:0]  rr_r;
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
    logic              locked_r;
    logic              bit2_s;
`endif

    logic [CPUS-1:0]   d_req_s;
    logic              d_valid_s;
    logic              i_valid_s;
    logic [IDX_W-1:0]  d_idx_s;
    logic [IDX_W-1:0]  i_idx_s;
    logic [IDX_W-1:0]  own_s;
    logic              active_s;
    logic              done_s;

    assign d_req_s = dREN | dWEN;
    assign own_s   = owner_r.cpu[IDX_W-1:0];

    rr_picker #(.N(CPUS), .IDX_W(IDX_W)) u_d_pick (
        .req   (d_req_s),
        .rr    (rr_r),
        .valid (d_valid_s),
        .idx   (d_idx_s)
    );

    rr_picker #(.N(CPUS), .IDX_W(IDX_W)) u_i_pick (
        .req   (iREN),
        .rr    (rr_r),
        .valid (i_valid_s),
        .idx   (i_idx_s)
    );

    // RAM request and wait/load returns follow the owner's live inputs.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        active_s = 1'b0;
        done_s   = 1'b0;
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
        bit2_s   = 1'b0;
`endif
        if (state_r == SERVE) begin
            if (owner_r.kind == KIND_D) begin
                // A simultaneous dREN/dWEN is a write.
                active_s     = dREN[own_s] | dWEN[own_s];
                ramWEN       = dWEN[own_s];
                ramREN       = dREN[own_s] & ~dWEN[own_s];
                ramaddr      = active_s ? daddr[own_s] : '0;
                ramstore     = dWEN[own_s] ? dstore[own_s] : '0;
                done_s       = active_s && (ramstate == ACCESS);
                dwait[own_s] = ~done_s;
                dload[own_s] = (done_s && !dWEN[own_s]) ? ramload : '0;
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
                bit2_s       = daddr[own_s][2];
`endif
            end else begin
                active_s     = iREN[own_s];
                ramREN       = iREN[own_s];
                ramaddr      = active_s ? iaddr[own_s] : '0;
                done_s       = active_s && (ramstate == ACCESS);
                iwait[own_s] = ~done_s;
                iload[own_s] = done_s ? ramload : '0;
            end
        end else begin
            active_s = 1'b0;
        end
    end

    // Arbitration FSM: grant in IDLE, track completion and block lock in SERVE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            owner_r  <= '{kind: KIND_D, cpu: '0};
            rr_r     <= '0;
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
            locked_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (d_valid_s) begin
                        owner_r <= '{kind: KIND_D, cpu: CPU_ID_W'(d_idx_s)};
                        state_r <= SERVE;
                    end else if (i_valid_s) begin
                        owner_r <= '{kind: KIND_I, cpu: CPU_ID_W'(i_idx_s)};
                        state_r <= SERVE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SERVE: begin
                    if (!active_s) begin
                        state_r  <= IDLE;
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
                        locked_r <= 1'b0;
`endif
                    end else if (done_s && owner_r.kind == KIND_D) begin
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
                        // Word 0 keeps the port; any bit-2 word ends the block.
                        locked_r <= ~bit2_s;
                        if (bit2_s) begin
                            rr_r    <= IDX_W'(next_cpu(owner_r.cpu, CPUS));
                            state_r <= IDLE;
                        end else begin
                            state_r <= SERVE;
                        end
`else
                        rr_r    <= IDX_W'(next_cpu(owner_r.cpu, CPUS));
                        state_r <= IDLE;
`endif
                    end else if (done_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r  <= SERVE;
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
                        locked_r <= locked_r;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected completions, a negedge monitor pops and compares.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [CPUS-1:0]     iREN, dREN, dWEN;
    word_t [CPUS-1:0]    iaddr, daddr, dstore;
    logic [CPUS-1:0]     iwait, dwait;
    word_t [CPUS-1:0]    iload, dload;
    logic                ramREN, ramWEN;
    word_t               ramaddr, ramstore, ramload;
    ramstate_t           ramstate;

    int lat     = 2;
    int ram_cnt = 0;
    int cyc     = 0;
    int n_chk   = 0;
    int n_fail  = 0;

    typedef struct {
        logic  is_d;
        int    cpu;
        logic  wen;
        word_t addr;
        word_t data;
        int    cyc;
    } exp_t;

    exp_t exp_q[$];

    mem_arbiter #(.CPUS(CPUS)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    function automatic word_t data_of(input word_t a);
        return 32'h8C22_0004 + (a - 32'h0000_0040);
    endfunction

    function automatic word_t store_of(input word_t a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // RAM model: ACCESS after lat cycles of a held request.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST || !(ramREN || ramWEN) || ramstate == ACCESS) ram_cnt <= 0;
        else ram_cnt <= ram_cnt + 1;
    end

    always_comb begin
        ramstate = FREE;
        ramload  = '0;
        if (ramREN || ramWEN) begin
            ramstate = (ram_cnt >= lat - 1) ? ACCESS : BUSY;
            ramload  = ramREN ? data_of(ramaddr) : 32'h0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic is_d, input int c, input logic wen, input word_t a, input int cy);
        exp_t e;
        e.is_d = is_d;
        e.cpu  = c;
        e.wen  = wen;
        e.addr = a;
        e.data = (is_d && wen) ? store_of(a) : data_of(a);
        e.cyc  = cy;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic is_d, input int c);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ack: %s cpu%0d wait low at addr %h, no completion expected",
                     is_d ? "dcache" : "icache", c, ramaddr);
        end else begin
            e = exp_q.pop_front();
            check("ack_kind", 32'(is_d), 32'(e.is_d));
            check("ack_cpu", 32'(c), 32'(e.cpu));
            check("ramaddr", ramaddr, e.addr);
            check("ramWEN", 32'(ramWEN), 32'(e.wen));
            check("ramREN", 32'(ramREN), 32'(!e.wen));
            if (e.is_d && e.wen) check("ramstore", ramstore, e.data);
            else if (e.is_d) check("dload", dload[c], e.data);
            else check("iload", iload[c], e.data);
            if (e.cyc >= 0) check("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Monitor: every wait-low is a completion and must match the queue head.
    always @(negedge CLK) begin
        if (!RST) begin
            for (int c = 0; c < CPUS; c++) begin
                if (!iwait[c]) pop_check(1'b0, c);
                if (!dwait[c]) pop_check(1'b1, c);
            end
        end
    end

    task automatic run_d(input int c, input logic wen, input word_t a0, input int nw);
        for (int w = 0; w < nw; w++) begin
            word_t a;
            int    t;
            a         = a0 + 32'(4 * w);
            daddr[c]  = a;
            dstore[c] = wen ? store_of(a) : 32'h0;
            dREN[c]   = 1'b1;
            dWEN[c]   = wen;
            t = 0;
            do begin
                @(negedge CLK);
                t++;
            end while (dwait[c] !== 1'b0 && t < 200);
            check("d_ack_timeout", 32'(dwait[c]), 32'h0);
            @(posedge CLK);
            #1;
        end
        dREN[c]   = 1'b0;
        dWEN[c]   = 1'b0;
        daddr[c]  = '0;
        dstore[c] = '0;
    endtask

    task automatic run_i(input int c, input word_t a);
        int t;
        iaddr[c] = a;
        iREN[c]  = 1'b1;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (iwait[c] !== 1'b0 && t < 200);
        check("i_ack_timeout", 32'(iwait[c]), 32'h0);
        @(posedge CLK);
        #1;
        iREN[c]  = 1'b0;
        iaddr[c] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d completions outstanding", exp_q.size());
        $fatal(1);
    end

    initial begin
        int t;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_iwait", 32'(iwait), 32'h3);
        check("rst_dwait", 32'(dwait), 32'h3);
        check("rst_ramREN", 32'(ramREN), 32'h0);
        check("rst_ramWEN", 32'(ramWEN), 32'h0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_iload0", iload[0], 32'h0);
        check("rst_dload1", dload[1], 32'h0);
        check("rst_state", 32'(dut.state_r), 32'(IDLE));
        check("rst_rr", 32'(dut.rr_r), 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Single icache read, latency 2: request in cycle 1, ack in cycle 2.
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h40;
        push(1'b0, 0, 1'b0, 32'h40, cyc + 2);
        @(negedge CLK);
        check("t1_c0_ramREN", 32'(ramREN), 32'h0);
        @(negedge CLK);
        check("t1_c1_ramREN", 32'(ramREN), 32'h1);
        check("t1_c1_ramaddr", ramaddr, 32'h40);
        check("t1_c1_iwait", 32'(iwait[0]), 32'h1);
        @(negedge CLK);
        @(posedge CLK); #1;
        iREN[0]  = 1'b0;
        iaddr[0] = '0;
        check("t1_drain", 32'(exp_q.size()), 32'h0);

        // Priority: dcache block beats a simultaneous icache read.
        push(1'b1, 1, 1'b0, 32'h100, -1);
        push(1'b1, 1, 1'b0, 32'h104, -1);
        push(1'b0, 0, 1'b0, 32'h80, -1);
        fork
            run_i(0, 32'h80);
            run_d(1, 1'b0, 32'h100, 2);
        join
        check("t2_drain", 32'(exp_q.size()), 32'h0);

        // Block lock: CPU0 fetch vs CPU1 writeback (dREN+dWEN together).
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
        push(1'b1, 0, 1'b0, 32'h200, -1);
        push(1'b1, 0, 1'b0, 32'h204, -1);
        push(1'b1, 1, 1'b1, 32'h300, -1);
        push(1'b1, 1, 1'b1, 32'h304, -1);
`else
        push(1'b1, 0, 1'b0, 32'h200, -1);
        push(1'b1, 1, 1'b1, 32'h300, -1);
        push(1'b1, 0, 1'b0, 32'h204, -1);
        push(1'b1, 1, 1'b1, 32'h304, -1);
`endif
        fork
            run_d(0, 1'b0, 32'h200, 2);
            run_d(1, 1'b1, 32'h300, 2);
        join
        check("t3_drain", 32'(exp_q.size()), 32'h0);

        // Round robin with zero-wait RAM: both dcaches busy for two blocks each.
        lat = 1;
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
        push(1'b1, 0, 1'b0, 32'h400, -1);
        push(1'b1, 0, 1'b0, 32'h404, -1);
        push(1'b1, 1, 1'b1, 32'h500, -1);
        push(1'b1, 1, 1'b1, 32'h504, -1);
        push(1'b1, 0, 1'b0, 32'h410, -1);
        push(1'b1, 0, 1'b0, 32'h414, -1);
        push(1'b1, 1, 1'b1, 32'h510, -1);
        push(1'b1, 1, 1'b1, 32'h514, -1);
`else
        push(1'b1, 0, 1'b0, 32'h400, -1);
        push(1'b1, 1, 1'b1, 32'h500, -1);
        push(1'b1, 0, 1'b0, 32'h404, -1);
        push(1'b1, 1, 1'b1, 32'h504, -1);
        push(1'b1, 0, 1'b0, 32'h410, -1);
        push(1'b1, 1, 1'b1, 32'h510, -1);
        push(1'b1, 0, 1'b0, 32'h414, -1);
        push(1'b1, 1, 1'b1, 32'h514, -1);
`endif
        fork
            begin
                run_d(0, 1'b0, 32'h400, 2);
                run_d(0, 1'b0, 32'h410, 2);
            end
            begin
                run_d(1, 1'b1, 32'h500, 2);
                run_d(1, 1'b1, 32'h510, 2);
            end
        join
        check("t4_drain", 32'(exp_q.size()), 32'h0);
        check("t4_rr", 32'(dut.rr_r), 32'h0);

        // Abort: CPU0 drops its request after word 0.
        lat = 2;
        push(1'b1, 0, 1'b0, 32'h600, -1);
        dREN[0]  = 1'b1;
        daddr[0] = 32'h600;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (dwait[0] !== 1'b0 && t < 200);
        check("t5_ack_timeout", 32'(dwait[0]), 32'h0);
        @(posedge CLK); #1;
        dREN[0]  = 1'b0;
        daddr[0] = '0;
        @(negedge CLK);
        check("t5_drop_ramREN", 32'(ramREN), 32'h0);
        check("t5_drop_ramWEN", 32'(ramWEN), 32'h0);
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
        check("t5_locked_set", 32'(dut.locked_r), 32'h1);
`endif
        @(negedge CLK);
        check("t5_state_idle", 32'(dut.state_r), 32'(IDLE));
`ifdef MEM_ARBITER_BLOCK_LOCK_EN
        check("t5_locked_clr", 32'(dut.locked_r), 32'h0);
`endif
        @(posedge CLK); #1;
        push(1'b1, 1, 1'b0, 32'h700, -1);
        push(1'b1, 1, 1'b0, 32'h704, -1);
        run_d(1, 1'b0, 32'h700, 2);
        check("t5_drain", 32'(exp_q.size()), 32'h0);

        // Reset mid-block while the RAM is still BUSY.
        push(1'b1, 0, 1'b0, 32'h800, -1);
        push(1'b1, 0, 1'b0, 32'h804, -1);
        run_d(0, 1'b0, 32'h800, 2);
        check("t6_rr_before", 32'(dut.rr_r), 32'h1);
        lat = 6;
        dREN[1]  = 1'b1;
        daddr[1] = 32'h900;
        @(negedge CLK);
        @(negedge CLK);
        check("t6_busy_ramREN", 32'(ramREN), 32'h1);
        check("t6_busy_ramaddr", ramaddr, 32'h900);
        check("t6_busy_state", 32'(ramstate), 32'(BUSY));
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("t6_iwait", 32'(iwait), 32'h3);
        check("t6_dwait", 32'(dwait), 32'h3);
        check("t6_ramREN", 32'(ramREN), 32'h0);
        check("t6_ramaddr", ramaddr, 32'h0);
        check("t6_state", 32'(dut.state_r), 32'(IDLE));
        check("t6_rr", 32'(dut.rr_r), 32'h0);
        dREN[1]  = 1'b0;
        daddr[1] = '0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("final_drain", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
